// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multicycle controller and its datapath.
// The master side is the controller; the slave side is the datapath/memory.
interface mc_ctrl_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic [2:0] alu_ctrl;
  logic       alu_src_a;
  logic [2:0] alu_src_b;
  logic       i_or_d;
  logic       mem_rd;
  logic       mem_wr;
  logic       ir_wr;
  logic       pc_wr;
  logic [1:0] pc_src;
  logic       reg_wr;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output alu_ctrl, alu_src_a, alu_src_b, i_or_d, mem_rd, mem_wr, ir_wr, pc_wr,
           pc_src, reg_wr, reg_dst, mem_to_reg, illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  alu_ctrl, alu_src_a, alu_src_b, i_or_d, mem_rd, mem_wr, ir_wr, pc_wr,
           pc_src, reg_wr, reg_dst, mem_to_reg, illegal, state
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS-subset controller: one state register, all control outputs
// decoded combinationally from state, opcode, funct, zero and mem_ready.
module mc_ctrl_fsm (
  input  logic          clk,
  input  logic          rst,
  mc_ctrl_fsm_if.master bus
);
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_WB_MEM   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_WB_R     = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_EXEC_I   = 4'd10;
  localparam logic [3:0] S_WB_I     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_OR   = 6'b100101;

  logic [3:0] state_q, state_d;
  logic       r_ok;
  logic [2:0] r_alu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  assign bus.state = state_q;

  always_comb begin
    r_ok  = 1'b1;
    r_alu = 3'b000;
    case (bus.funct)
      FN_ADDU: r_alu = 3'b001;
      FN_SUBU: r_alu = 3'b010;
      FN_OR:   r_alu = 3'b011;
      default: r_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    bus.alu_ctrl   = 3'b000;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 3'b000;
    bus.i_or_d     = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.ir_wr      = 1'b0;
    bus.pc_wr      = 1'b0;
    bus.pc_src     = 2'b00;
    bus.reg_wr     = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.illegal    = 1'b0;
    // Outputs are forced quiet while reset is held, even though state already reads FETCH.
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          bus.mem_rd    = 1'b1;
          bus.alu_src_b = 3'b001;
          bus.alu_ctrl  = 3'b001;
          bus.ir_wr     = bus.mem_ready;
          bus.pc_wr     = bus.mem_ready;
          if (bus.mem_ready) state_d = S_DECODE;
        end
        S_DECODE: begin
          bus.alu_src_b = 3'b011;
          bus.alu_ctrl  = 3'b001;
          case (bus.opcode)
            OP_RTYPE: begin
              if (r_ok) state_d = S_EXEC_R;
              else begin
                state_d     = S_FETCH;
                bus.illegal = 1'b1;
              end
            end
            OP_LW, OP_SW:   state_d = S_MEM_ADDR;
            OP_BEQ:         state_d = S_BRANCH;
            OP_J:           state_d = S_JUMP;
            OP_ORI, OP_LUI: state_d = S_EXEC_I;
            default: begin
              state_d     = S_FETCH;
              bus.illegal = 1'b1;
            end
          endcase
        end
        S_MEM_ADDR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 3'b010;
          bus.alu_ctrl  = 3'b001;
          state_d       = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          bus.mem_rd = 1'b1;
          bus.i_or_d = 1'b1;
          if (bus.mem_ready) state_d = S_WB_MEM;
        end
        S_WB_MEM: begin
          bus.reg_wr     = 1'b1;
          bus.mem_to_reg = 1'b1;
          state_d        = S_FETCH;
        end
        S_MEM_WR: begin
          bus.mem_wr = 1'b1;
          bus.i_or_d = 1'b1;
          if (bus.mem_ready) state_d = S_FETCH;
        end
        S_EXEC_R: begin
          bus.alu_src_a = 1'b1;
          bus.alu_ctrl  = r_alu;
          state_d       = S_WB_R;
        end
        S_WB_R: begin
          bus.reg_wr  = 1'b1;
          bus.reg_dst = 1'b1;
          state_d     = S_FETCH;
        end
        S_BRANCH: begin
          bus.alu_src_a = 1'b1;
          bus.alu_ctrl  = 3'b010;
          bus.pc_src    = 2'b01;
          bus.pc_wr     = bus.zero;
          state_d       = S_FETCH;
        end
        S_JUMP: begin
          bus.pc_src = 2'b10;
          bus.pc_wr  = 1'b1;
          state_d    = S_FETCH;
        end
        S_EXEC_I: begin
          if (bus.opcode == OP_LUI) begin
            bus.alu_src_b = 3'b101;
            bus.alu_ctrl  = 3'b000;
          end else begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 3'b100;
            bus.alu_ctrl  = 3'b011;
          end
          state_d = S_WB_I;
        end
        S_WB_I: begin
          bus.reg_wr = 1'b1;
          state_d    = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: each instruction is expanded into its expected
// per-cycle control trace from the instruction's micro-steps, then replayed.
module tb_mc_ctrl_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mc_ctrl_fsm_if bus ();
  mc_ctrl_fsm u_dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [17:0] obs;
  assign obs = {bus.alu_ctrl, bus.alu_src_a, bus.alu_src_b, bus.i_or_d, bus.mem_rd,
                bus.mem_wr, bus.ir_wr, bus.pc_wr, bus.pc_src, bus.reg_wr, bus.reg_dst,
                bus.mem_to_reg, bus.illegal};

  typedef struct {
    logic [3:0]  st;
    logic        mr;
    logic        z;
    logic [17:0] o;
  } rec_t;

  rec_t        trace[$];
  logic [5:0]  cur_op;
  logic [5:0]  cur_fn;

  function automatic logic [17:0] o(input logic [2:0] ac, input logic asa, input logic [2:0] asb,
                                    input logic iod, input logic mrd, input logic mwr,
                                    input logic irw, input logic pcw, input logic [1:0] pcs,
                                    input logic rw, input logic rd, input logic m2r,
                                    input logic ill);
    return {ac, asa, asb, iod, mrd, mwr, irw, pcw, pcs, rw, rd, m2r, ill};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [3:0] st, input logic mr, input logic z, input logic [17:0] ov);
    rec_t r;
    r.st = st; r.mr = mr; r.z = z; r.o = ov;
    trace.push_back(r);
  endtask

  function automatic logic [2:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'b100001: return 3'b001;
      6'b100011: return 3'b010;
      6'b100101: return 3'b011;
      default:   return 3'b111;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: return (r_alu(fn) == 3'b111);
      6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001101, 6'b001111: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Expected trace of one instruction: fw fetch waits, mw data-memory waits.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                       input logic z);
    logic ill;
    ill = is_illegal(op, fn);
    cur_op = op;
    cur_fn = fn;
    trace.delete();
    for (int i = 0; i < fw; i++)
      push(4'd0, 1'b0, rbit(), o(3'b001, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    push(4'd0, 1'b1, rbit(), o(3'b001, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    push(4'd1, rbit(), rbit(), o(3'b001, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, ill));
    if (!ill) begin
      case (op)
        6'b000000: begin
          push(4'd6, rbit(), rbit(), o(r_alu(fn), 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
          push(4'd7, rbit(), rbit(), o(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0));
        end
        6'b100011, 6'b101011: begin
          push(4'd2, rbit(), rbit(), o(3'b001, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
          for (int i = 0; i <= mw; i++) begin
            if (op == 6'b100011)
              push(4'd3, (i == mw), rbit(), o(3'b000, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
            else
              push(4'd5, (i == mw), rbit(), o(3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
          end
          if (op == 6'b100011)
            push(4'd4, rbit(), rbit(), o(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0));
        end
        6'b000100:
          push(4'd8, rbit(), z, o(3'b010, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, z, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0));
        6'b000010:
          push(4'd9, rbit(), rbit(), o(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0));
        default: begin
          if (op == 6'b001111)
            push(4'd10, rbit(), rbit(), o(3'b000, 1'b0, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
          else
            push(4'd10, rbit(), rbit(), o(3'b011, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
          push(4'd11, rbit(), rbit(), o(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
        end
      endcase
    end
  endtask

  // Caller is positioned just after a falling edge; so is the task on return.
  task automatic run(input string tag);
    foreach (trace[i]) begin
      bus.opcode    = cur_op;
      bus.funct     = cur_fn;
      bus.zero      = trace[i].z;
      bus.mem_ready = trace[i].mr;
      #2;
      checks++;
      assert (bus.state === trace[i].st) else begin
        errors++;
        $error("FAIL %s state step %0d: got %0d want %0d", tag, i, bus.state, trace[i].st);
      end
      checks++;
      assert (obs === trace[i].o) else begin
        errors++;
        $error("FAIL %s outputs step %0d (state %0d): got %b want %b", tag, i, trace[i].st, obs, trace[i].o);
      end
      @(negedge clk);
    end
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 8))
      0, 7:    return 6'b000000;
      1:       return 6'b100011;
      2:       return 6'b101011;
      3:       return 6'b000100;
      4:       return 6'b000010;
      5:       return 6'b001101;
      6:       return 6'b001111;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  function automatic logic [5:0] pick_fn();
    case ($urandom_range(0, 3))
      0:       return 6'b100001;
      1:       return 6'b100011;
      2:       return 6'b100101;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  function automatic int pick_wait();
    return ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
  endfunction

  initial begin
    bus.opcode    = 6'b100011;
    bus.funct     = 6'b000000;
    bus.zero      = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    #2;
    checks++;
    assert (bus.state === 4'd0) else begin
      errors++; $error("FAIL reset_state: got %0d want 0", bus.state);
    end
    checks++;
    assert (obs === 18'd0) else begin
      errors++; $error("FAIL reset_outputs: got %b want %b", obs, 18'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    build(6'b000000, 6'b100001, 0, 0, 1'b0); run("addu");
    build(6'b100011, 6'b000000, 0, 3, 1'b0); run("lw_wait3");
    build(6'b000100, 6'b000000, 0, 0, 1'b1); run("beq_taken");
    build(6'b000100, 6'b000000, 0, 0, 1'b0); run("beq_not_taken");
    build(6'b001111, 6'b000000, 0, 0, 1'b0); run("lui");
    build(6'b001101, 6'b000000, 0, 0, 1'b0); run("ori");
    build(6'b111111, 6'b000000, 0, 0, 1'b0); run("illegal_op");
    build(6'b000000, 6'b000000, 0, 0, 1'b0); run("illegal_funct");
    build(6'b000000, 6'b100011, 2, 0, 1'b0); run("subu_fetchwait");
    build(6'b000000, 6'b100101, 0, 0, 1'b0); run("or");
    build(6'b101011, 6'b000000, 1, 2, 1'b0); run("sw_wait2");
    build(6'b000010, 6'b000000, 0, 0, 1'b0); run("j");

    for (int n = 0; n < 150; n++) begin
      build(pick_op(), pick_fn(), pick_wait(), pick_wait(), rbit());
      run("random");
    end

    // Abort a store while it is stalled on memory.
    build(6'b101011, 6'b000000, 0, 3, 1'b0);
    while (trace.size() > 5) void'(trace.pop_back());
    run("sw_pre_reset");
    bus.mem_ready = 1'b0;
    #2;
    checks++;
    assert (bus.state === 4'd5 && bus.mem_wr === 1'b1) else begin
      errors++; $error("FAIL sw_waiting: got state %0d mem_wr %b want 5 1", bus.state, bus.mem_wr);
    end
    rst = 1'b1;
    #1;
    checks++;
    assert (bus.state === 4'd0) else begin
      errors++; $error("FAIL midreset_state: got %0d want 0", bus.state);
    end
    checks++;
    assert (obs === 18'd0) else begin
      errors++; $error("FAIL midreset_outputs: got %b want %b", obs, 18'd0);
    end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    #2;
    checks++;
    assert (obs === 18'd0 && bus.state === 4'd0) else begin
      errors++; $error("FAIL held_reset: got state %0d outputs %b want 0 %b", bus.state, obs, 18'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    build(6'b000000, 6'b100001, 1, 0, 1'b0); run("post_reset_addu");
    build(6'b100011, 6'b000000, 0, 1, 1'b0); run("post_reset_lw");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 clk  in  1  sole clock; all state changes on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 opcode  in  6  IR[31:26]; valid from DECODE onward.
REQ-004 funct  in  6  IR[5:0]; valid from DECODE onward.
REQ-005 zero  in  1  ALU zero indicator from the current cycle's ALU result.
REQ-006 mem_ready  in  1  memory completes the current access this cycle.
REQ-007 alu_ctrl  out  3  ALU function: 001 add, 010 sub, 011 or, 000 pass B.
REQ-008 alu_src_a  out  1  0=PC, 1=register A.
REQ-009 alu_src_b  out  3  000 reg B, 001 const 4, 010 sext imm, 011 sext imm<<2, 100 zext imm, 101 imm<<16.
REQ-010 i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
REQ-011 mem_rd / mem_wr  out  1 each  memory read / write request.
REQ-012 ir_wr / pc_wr  out  1 each  IR load / unconditional PC load.
REQ-013 pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-014 reg_wr / reg_dst / mem_to_reg  out  1 each  RF write, rd(1)/rt(0), MDR(1)/ALUOut(0).
REQ-015 illegal  out  1  one-cycle pulse on unsupported opcode/funct.
REQ-016 state  out  4  current state code, for debug.

Function
REQ-017 States (code): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, WB_MEM 4, MEM_WR 5, EXEC_R 6, WB_R 7, BRANCH 8, JUMP 9, EXEC_I 10, WB_I 11.
REQ-018 All outputs not listed for a state SHALL be 0; alu_ctrl defaults to 000.
REQ-019 FETCH: mem_rd=1, i_or_d=0, alu_src_a=0, alu_src_b=001, alu_ctrl=001; ir_wr=pc_wr=mem_ready; hold in FETCH while mem_ready=0, else go DECODE.
REQ-020 DECODE: alu_src_a=0, alu_src_b=011, alu_ctrl=001 (branch target into ALUOut); next by opcode.
REQ-021 Decode map: 000000->EXEC_R; 100011 lw, 101011 sw->MEM_ADDR; 000100 beq->BRANCH; 000010 j->JUMP; 001101 ori, 001111 lui->EXEC_I; other->FETCH with illegal=1.
REQ-022 R-type funct: 100001 addu->001, 100011 subu->010, 100101 or->011; other funct->FETCH from DECODE with illegal=1, no writes.
REQ-023 MEM_ADDR: alu_src_a=1, alu_src_b=010, alu_ctrl=001; lw->MEM_RD, sw->MEM_WR.
REQ-024 MEM_RD: mem_rd=1, i_or_d=1; hold until mem_ready, then WB_MEM.
REQ-025 WB_MEM: reg_wr=1, reg_dst=0, mem_to_reg=1; ->FETCH.
REQ-026 MEM_WR: mem_wr=1, i_or_d=1; hold until mem_ready, then FETCH.
REQ-027 EXEC_R: alu_src_a=1, alu_src_b=000, alu_ctrl per REQ-022; ->WB_R. WB_R: reg_wr=1, reg_dst=1; ->FETCH.
REQ-028 EXEC_I: ori alu_src_a=1, alu_src_b=100, alu_ctrl=011; lui alu_src_b=101, alu_ctrl=000; ->WB_I. WB_I: reg_wr=1, reg_dst=0; ->FETCH.
REQ-029 BRANCH: alu_src_a=1, alu_src_b=000, alu_ctrl=010, pc_src=01, pc_wr=zero; ->FETCH.
REQ-030 JUMP: pc_src=10, pc_wr=1; ->FETCH.
REQ-031 Latency excluding memory wait: beq/j 3, R/ori/lui/sw 4, lw 5 cycles.
REQ-032 mem_rd/mem_wr SHALL stay asserted with stable i_or_d every waiting cycle; never both high.
REQ-033 Outputs are combinational from state, opcode, funct, zero, mem_ready; no latches (full defaults).

Reset
REQ-034 rst=1 forces state=FETCH immediately, mid-operation included (pending access abandoned); while rst=1 all outputs 0; first FETCH cycle follows rst deassertion.

Verification
REQ-035 addu (opcode 0, funct 100001), mem_ready=1: states 0,1,6,7,0; alu_ctrl=001 in EXEC_R; reg_wr=1, reg_dst=1 in WB_R only.
REQ-036 lw, mem_ready low 3 cycles in MEM_RD: state 3 held 4 cycles with mem_rd=1, i_or_d=1; then WB_MEM with mem_to_reg=1.
REQ-037 beq with zero=1 then zero=0: pc_wr=1, pc_src=01, alu_ctrl=010 in BRANCH first run; pc_wr=0 second.
REQ-038 lui: EXEC_I alu_src_b=101, alu_ctrl=000; ori: alu_src_b=100, alu_ctrl=011; both reg_wr in WB_I.
REQ-039 opcode 111111, and opcode 0 funct 000000: DECODE->FETCH, illegal=1 one cycle, no reg_wr/mem_wr/pc_wr.
REQ-040 rst pulsed during MEM_WR wait: state=0 and mem_wr=0 same cycle; normal fetch resumes after release.
